int2float_reg: RTL and testbench
================================

Name: int2float_reg

Overview:
- Registered unsigned-integer-to-minifloat converter: 11-bit unsigned integer B in, 7-bit float out with a 3-bit exponent E and a 4-bit mantissa M.
- The hidden leading one is dropped and the result is truncated; there is no rounding.
- Used as a small numeric-compression stage in datapaths, with one clock and one cycle of latency.

Parameters:
- INT_W, 11, input integer width. Fixed; the conversion is only defined for 11.
- EXP_W, 3, exponent width.
- MAN_W, 4, mantissa width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  B is valid this cycle
- B  input  11  unsigned integer operand, B[10] is the MSB
- out_valid  output  1  E/M hold a fresh result
- E  output  3  exponent, E[2] is the MSB
- M  output  4  mantissa fraction bits, M[3] is the MSB

Behaviour:
- Conversion function (combinational core):
  - If B < 16: E = 0, M = B[3:0]. This is the denormal/linear range.
  - Otherwise let p = index of the highest set bit of B (4..10). Then E = p-3 (range 1..7) and M = B[p-1:p-4].
  - Bits below p-4 are discarded (truncation).
- Decoded value:
  - E = 0: value = M.
  - E > 0: value = (16+M) << (E-1).
  - This gives a monotonic mapping; the maximum code is E=7, M=15 for B ≥ 1984.
- Leading-one detection: priority over B[10:4], with the highest set bit winning.
- Timing:
  - On each rising clk edge with rst=0, E/M register the converted value of B sampled at that edge.
  - out_valid registers in_valid.
  - Latency is exactly 1 cycle; throughput is 1 per cycle.
  - No backpressure; out_valid is informational only.
- Data capture: E/M update every cycle regardless of in_valid, so the datapath is free-running. Consumers qualify results with out_valid.
- Reset:
  - rst=1 at a clock edge forces E=0, M=0, out_valid=0. These are the reset values of all outputs.
  - Reset takes priority over any simultaneous in_valid.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid result appears one cycle after the first in_valid sampled with rst=0.
- No X propagation: any fully defined B produces defined outputs. There are no illegal input codes.

Decomposition:
- Shared package int2float_pkg holds the constants INT_W=11, EXP_W=3, MAN_W=4 and DENORM_LIMIT=16.
- One sub-module, int2float_lod (combinational leading-one detector and mantissa extractor):
  - Inputs: B[10:0].
  - Outputs: E[2:0], M[3:0].
- The top wrapper adds the output registers, reset and valid pipeline.

Test Plan:
- Reset: hold rst=1 for 2 cycles with B=0x7FF, in_valid=1 -> E=0, M=0, out_valid=0. Release rst -> next cycle E=7, M=15, out_valid=1.
- Denormal/boundary sweep (one cycle after each input):
  - B=0 -> E=0, M=0.
  - B=15 -> E=0, M=15.
  - B=16 -> E=1, M=0.
  - B=31 -> E=1, M=15.
  - B=32 -> E=2, M=0.
- Truncation:
  - B=0x554 (alternating bits 10,8,6,4,2) -> E=7, M=5.
  - B=0x2AB -> E=6, M=5.
  - B=0x5A5 -> E=7, M=6.
  - B=1983 -> E=7, M=14.
- Exhaustive: all 2048 B values back-to-back with in_valid=1. Check against the reference model with 1-cycle latency; results must be monotonic non-decreasing in B.
- Valid pipeline: toggle in_valid 1,0,1 -> out_valid 1,0,1 delayed by one cycle. Assert rst in the cycle after an in_valid -> out_valid=0 and E/M=0 on the next edge.
- Static patterns:
  - Hold B=0 for 170 cycles -> E=0, M=0 constant.
  - Hold B=0x7FF for 170 cycles -> E=7, M=15 constant.

Source files
------------

// File: rtl/int2float_pkg.sv
// Shared constants and result payload for the unsigned-integer to minifloat converter.
package int2float_pkg;

  localparam int unsigned INT_W        = 11;
  localparam int unsigned EXP_W        = 3;
  localparam int unsigned MAN_W        = 4;
  localparam int unsigned DENORM_LIMIT = 16;

  typedef struct packed {
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } mini_float_t;

endpackage

// File: rtl/int2float_lod.sv
// Leading-one detector and truncating mantissa extractor (combinational).
module int2float_lod
  import int2float_pkg::*;
(
  input  logic [INT_W-1:0] B,
  output logic [EXP_W-1:0] E,
  output logic [MAN_W-1:0] M
);

  // Later (higher) bit positions overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    E = '0;
    M = B[MAN_W-1:0];
    for (int i = MAN_W; i < INT_W; i++) begin
      if (B[i]) begin
        E = EXP_W'(i - 3);
        M = B[i-1 -: MAN_W];
      end
    end
  end

endmodule

// File: rtl/int2float_reg.sv
// Registered 11-bit unsigned to 7-bit minifloat converter, one cycle latency.
module int2float_reg
  import int2float_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [INT_W-1:0] B,
  output logic             out_valid,
  output logic [EXP_W-1:0] E,
  output logic [MAN_W-1:0] M
);

  mini_float_t conv_c;

  int2float_lod u_lod (
    .B (B),
    .E (conv_c.e),
    .M (conv_c.m)
  );

  // Datapath is free-running; out_valid alone qualifies the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      E         <= '0;
      M         <= '0;
    end else begin
      out_valid <= in_valid;
      E         <= conv_c.e;
      M         <= conv_c.m;
    end
  end

endmodule

// File: tb/tb_int2float_reg.sv
// Self-checking bench for int2float_reg: behavioural model, literal pins, sweeps and random traffic.
module tb_int2float_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [10:0] B = '0;
  logic        out_valid;
  logic [2:0]  E;
  logic [3:0]  M;

  int n_checks = 0;
  int n_fail   = 0;

  int2float_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .B         (B),
    .out_valid (out_valid),
    .E         (E),
    .M         (M)
  );

  always #5 clk = ~clk;

  // Reference: normalise by halving until the value fits in [16,32), counting halvings.
  function automatic logic [6:0] model(input int b);
    int v;
    int e;
    if (b < 16) return {3'd0, 4'(b)};
    v = b;
    e = 1;
    while (v >= 32) begin
      v = v / 2;
      e = e + 1;
    end
    return {3'(e), 4'(v - 16)};
  endfunction

  function automatic int decode(input logic [2:0] e, input logic [3:0] m);
    if (e == 3'd0) return int'(m);
    return (16 + int'(m)) << (int'(e) - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input int b);
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    B        = 11'(b);
  endtask

  // Model pipeline: what the outputs must show after each edge.
  logic       mdl_ready = 1'b0;
  logic       mdl_valid;
  logic [6:0] mdl_em;

  always @(posedge clk) begin
    mdl_ready <= 1'b1;
    if (rst) begin
      mdl_valid <= 1'b0;
      mdl_em    <= '0;
    end else begin
      mdl_valid <= in_valid;
      mdl_em    <= model(int'(B));
    end
  end

  always @(negedge clk) begin
    if (mdl_ready) begin
      chk("out_valid", int'(out_valid), int'(mdl_valid));
      chk("E", int'(E), int'(mdl_em[6:4]));
      chk("M", int'(M), int'(mdl_em[3:0]));
    end
  end

  // Apply one value, then check the DUT and the model against hand-computed codes.
  task automatic check_lit(input string name, input int b, input int e, input int m);
    logic [6:0] r;
    drive(1'b0, 1'b1, b);
    @(posedge clk);
    @(negedge clk);
    r = model(b);
    chk({name, " model E"}, int'(r[6:4]), e);
    chk({name, " model M"}, int'(r[3:0]), m);
    chk({name, " E"}, int'(E), e);
    chk({name, " M"}, int'(M), m);
    chk({name, " valid"}, int'(out_valid), 1);
  endtask

  initial begin
    int prev;
    int cur;

    // Reset held with activity on the inputs.
    rst = 1'b1; in_valid = 1'b1; B = 11'h7FF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst E", int'(E), 0);
    chk("rst M", int'(M), 0);
    chk("rst valid", int'(out_valid), 0);
    drive(1'b0, 1'b1, 11'h7FF);
    @(posedge clk);
    @(negedge clk);
    chk("post-rst E", int'(E), 7);
    chk("post-rst M", int'(M), 15);
    chk("post-rst valid", int'(out_valid), 1);

    // Boundaries and truncation.
    check_lit("b0",    0,      0, 0);
    check_lit("b15",   15,     0, 15);
    check_lit("b16",   16,     1, 0);
    check_lit("b31",   31,     1, 15);
    check_lit("b32",   32,     2, 0);
    check_lit("b554",  'h554,  7, 5);
    check_lit("b2AB",  'h2AB,  6, 5);
    check_lit("b5A5",  'h5A5,  7, 6);
    check_lit("b1983", 1983,   7, 14);
    check_lit("b1984", 1984,   7, 15);

    // Exhaustive back-to-back sweep with a monotonicity check on the decoded outputs.
    prev = 0;
    for (int b = 0; b <= 2048; b++) begin
      drive(1'b0, 1'b1, (b > 2047) ? 2047 : b);
      if (b >= 2) begin
        cur = decode(E, M);
        chk("monotonic", int'(cur >= prev), 1);
        prev = cur;
      end else if (b == 1) begin
        prev = decode(E, M);
      end
    end

    // Valid pipeline toggling.
    drive(1'b0, 1'b1, 100);
    drive(1'b0, 1'b0, 200);
    drive(1'b0, 1'b1, 300);
    drive(1'b0, 1'b0, 300);

    // Reset the cycle after a valid input discards it.
    drive(1'b0, 1'b1, 11'h7FF);
    drive(1'b1, 1'b0, 11'h7FF);
    @(posedge clk);
    @(negedge clk);
    chk("midrst valid", int'(out_valid), 0);
    chk("midrst E", int'(E), 0);
    chk("midrst M", int'(M), 0);

    // Static patterns.
    for (int i = 0; i < 170; i++) drive(1'b0, 1'b1, 0);
    for (int i = 0; i < 170; i++) drive(1'b0, 1'b1, 11'h7FF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)));

    drive(1'b0, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
